// File: rtl/scan_block_ctrl.sv
// Serial-to-block assembler feeding a cipher core.
// Accepts scan bits MSB-first into a BLOCK_BITS-wide buffer. Each completed
// block is handed off over a valid/ready handshake. A run covers num_blocks
// blocks and ends with a one-cycle done pulse; abort ends it early with no pulse.
module scan_block_ctrl #(
    parameter int BLOCK_BITS = 128,
    parameter int CNT_W      = 7
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [7:0]            num_blocks,
    input  logic                  scan_in,
    input  logic                  scan_valid,
    output logic                  scan_ready,
    output logic [BLOCK_BITS-1:0] blk_data,
    output logic                  blk_valid,
    input  logic                  blk_ready,
    output logic [7:0]            blk_count,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [BLOCK_BITS-1:0] buf_q, buf_d;
    logic [BLOCK_BITS-1:0] blk_data_q, blk_data_d;
    logic [7:0]            blk_count_q, blk_count_d;
    logic [7:0]            num_blocks_q, num_blocks_d;

    logic accept;
    logic last_bit;
    logic handshake;

    // Outputs decode directly from the registered state, so reset clears them
    // immediately without waiting for a clock edge.
    assign scan_ready = (state_q == SHIFT);
    assign blk_valid  = (state_q == HOLD);
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign blk_data   = blk_data_q;
    assign blk_count  = blk_count_q;

    assign accept    = scan_ready && scan_valid;
    assign last_bit  = (bit_cnt_q == CNT_W'(BLOCK_BITS - 1));
    assign handshake = blk_valid && blk_ready;

    // The k-th accepted bit lands at buffer[BLOCK_BITS-1-k]. Every other bit,
    // and every bit in a cycle with no accept, keeps its value.
    generate
        for (genvar gi = 0; gi < BLOCK_BITS; gi++) begin : g_pack
            assign buf_d[gi] = (accept && (bit_cnt_q == CNT_W'(BLOCK_BITS - 1 - gi)))
                               ? scan_in : buf_q[gi];
        end
    endgenerate

    // Next-state logic: run sequencing, block capture and handshake counting.
    // abort overrides the state and counter but still lets a HOLD handshake count.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        blk_data_d   = blk_data_q;
        blk_count_d  = blk_count_q;
        num_blocks_d = num_blocks_q;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    num_blocks_d = num_blocks;
                    blk_count_d  = 8'd0;
                    bit_cnt_d    = '0;
                    state_d      = (num_blocks != 8'd0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                if (accept) begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (last_bit) begin
                        // Capture includes the bit being accepted this cycle.
                        blk_data_d = buf_d;
                        state_d    = HOLD;
                    end
                end
            end
            HOLD: begin
                if (handshake) begin
                    blk_count_d = blk_count_q + 8'd1;
                    bit_cnt_d   = '0;
                    state_d     = ((blk_count_q + 8'd1) == num_blocks_q) ? DONE : SHIFT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
        end
    end

    // State and datapath registers, cleared asynchronously by reset_n.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            buf_q        <= '0;
            blk_data_q   <= '0;
            blk_count_q  <= 8'd0;
            num_blocks_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            buf_q        <= buf_d;
            blk_data_q   <= blk_data_d;
            blk_count_q  <= blk_count_d;
            num_blocks_q <= num_blocks_d;
        end
    end

endmodule

// File: tb/tb_scan_block_ctrl.sv
// Self-checking bench for scan_block_ctrl.
// Table-driven runs plus hand-written abort/reset sequences. Expected blocks are
// queued when their bits are driven and are popped at each observed handshake.
module tb_scan_block_ctrl;

    localparam int BB = 128;
    localparam int CW = 7;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic          abort;
    logic [7:0]    num_blocks;
    logic          scan_in;
    logic          scan_valid;
    logic          scan_ready;
    logic [BB-1:0] blk_data;
    logic          blk_valid;
    logic          blk_ready;
    logic [7:0]    blk_count;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    scan_block_ctrl #(.BLOCK_BITS(BB), .CNT_W(CW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .abort      (abort),
        .num_blocks (num_blocks),
        .scan_in    (scan_in),
        .scan_valid (scan_valid),
        .scan_ready (scan_ready),
        .blk_data   (blk_data),
        .blk_valid  (blk_valid),
        .blk_ready  (blk_ready),
        .blk_count  (blk_count),
        .busy       (busy),
        .done       (done)
    );

    typedef struct {
        int nblk;       // num_blocks driven at start
        int pat;        // 0 alternating 1,0 / 1 all ones / 2 random
        int gap;        // 1: scan_valid toggles 1,0
        int stall_blk;  // block index held 10 cycles in HOLD, -1 none
        int tput;       // check 129-cycle spacing between handshakes
        int exp_count;  // expected final blk_count
        int exp_done;   // expected number of done pulses
    } vec_t;

    int            compared   = 0;
    int            mismatched = 0;
    logic [BB-1:0] exp_q[$];
    int            done_total = 0;
    int            cyc        = 0;
    int            last_hs    = -1;
    bit            tput_on    = 1'b0;
    bit            seen_ready = 1'b0;
    bit            seen_valid = 1'b0;
    vec_t          vecs[5];

    task automatic check(input string name, input logic [BB-1:0] act, input logic [BB-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s: wait expired, required event never seen", name);
    endtask

    // Observes DUT outputs at the falling edge: handshakes, done pulses, exclusivity.
    task automatic monitor();
        logic [BB-1:0] exp;
        if (done) done_total++;
        if (scan_ready) seen_ready = 1'b1;
        if (blk_valid) seen_valid = 1'b1;
        if (scan_ready && blk_valid) check("ready_valid_exclusive", 1, 0);
        if (blk_valid && blk_ready) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL blk_unexpected: got %0h, required no block", blk_data);
            end else begin
                exp = exp_q.pop_front();
                check("blk_data", blk_data, exp);
                $display("handshake cyc=%0d blk_data=%0h", cyc, blk_data);
            end
            if (tput_on && last_hs >= 0) check("block_period", BB'(cyc - last_hs), BB'(129));
            last_hs = cyc;
        end
    endtask

    // One clock: sample at negedge, then return 1 time unit after the rising edge.
    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send_block(input logic [BB-1:0] data, input int gap, input int nbits);
        int w;
        for (int k = 0; k < nbits; k++) begin
            if (gap != 0 && k > 0) begin
                // Bubble cycle carrying the wrong bit value; must not be absorbed.
                scan_valid = 1'b0;
                scan_in    = ~data[BB-1-k];
                step();
            end
            scan_valid = 1'b1;
            scan_in    = data[BB-1-k];
            w = 0;
            while (!scan_ready && w < 300) begin
                step();
                w++;
            end
            if (!scan_ready) begin
                timeout("scan_ready_wait");
                scan_valid = 1'b0;
                return;
            end
            step();
        end
        scan_valid = 1'b0;
    endtask

    function automatic logic [BB-1:0] make_block(input int pat);
        logic [BB-1:0] d;
        case (pat)
            0:       d = {64{2'b10}};
            1:       d = {BB{1'b1}};
            default: d = {$urandom, $urandom, $urandom, $urandom};
        endcase
        return d;
    endfunction

    task automatic run_case(input vec_t v);
        int            d0;
        int            w;
        logic [BB-1:0] data;
        d0         = done_total;
        seen_ready = 1'b0;
        seen_valid = 1'b0;
        last_hs    = -1;
        tput_on    = (v.tput != 0);
        blk_ready  = 1'b1;
        num_blocks = 8'(v.nblk);
        start      = 1'b1;
        step();
        start      = 1'b0;
        // A later change of num_blocks must not alter the run length.
        num_blocks = 8'(v.nblk + 5);
        if (v.nblk == 0) begin
            check("zero_done_next_cycle", done, 1);
            check("zero_no_ready", scan_ready, 0);
            step();
            check("zero_busy_after", busy, 0);
            step();
        end else begin
            for (int b = 0; b < v.nblk; b++) begin
                data = make_block(v.pat);
                exp_q.push_back(data);
                send_block(data, v.gap, BB);
                check("valid_after_last_bit", blk_valid, 1);
                if (b == v.stall_blk) begin
                    blk_ready = 1'b0;
                    for (int i = 0; i < 10; i++) begin
                        check("stall_scan_ready", scan_ready, 0);
                        check("stall_blk_data", blk_data, data);
                        step();
                    end
                    blk_ready = 1'b1;
                end
            end
            w = 0;
            while (done_total == d0 && w < 20) begin
                step();
                w++;
            end
            if (done_total == d0) timeout("done_wait");
            step();
            step();
        end
        check("done_pulses", BB'(done_total - d0), BB'(v.exp_done));
        check("blk_count_final", blk_count, BB'(v.exp_count));
        check("busy_final", busy, 0);
        check("queue_drained", BB'(exp_q.size()), 0);
        if (v.nblk == 0) begin
            check("zero_never_ready", seen_ready, 0);
            check("zero_never_valid", seen_valid, 0);
        end
        tput_on = 1'b0;
        $display("case nblk=%0d pat=%0d gap=%0d stall=%0d blk_count=%0d", v.nblk, v.pat, v.gap, v.stall_blk, blk_count);
    endtask

    initial begin
        int            d0;
        logic [BB-1:0] data;
        vec_t          rv;

        vecs[0] = '{1, 0, 0, -1, 0, 1, 1};
        vecs[1] = '{3, 2, 0,  1, 0, 3, 1};
        vecs[2] = '{1, 1, 1, -1, 0, 1, 1};
        vecs[3] = '{0, 0, 0, -1, 0, 0, 1};
        vecs[4] = '{2, 2, 0, -1, 1, 2, 1};

        reset_n    = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        num_blocks = 8'd0;
        scan_in    = 1'b0;
        scan_valid = 1'b0;
        blk_ready  = 1'b1;
        #12;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_scan_ready", scan_ready, 0);
        check("reset_blk_valid", blk_valid, 0);
        check("reset_blk_count", blk_count, 0);
        check("reset_blk_data", blk_data, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 5; i++) run_case(vecs[i]);

        // Abort after 60 bits of the first block, then a clean restart.
        exp_q.delete();
        d0         = done_total;
        num_blocks = 8'd1;
        start      = 1'b1;
        step();
        start = 1'b0;
        data  = make_block(2);
        send_block(data, 0, 60);
        check("abort_pre_busy", busy, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_scan_ready", scan_ready, 0);
        check("abort_blk_count", blk_count, 0);
        step();
        step();
        check("abort_no_done", BB'(done_total - d0), 0);
        $display("abort after 60 bits: busy=%0d blk_count=%0d", busy, blk_count);
        rv = '{1, 2, 0, -1, 0, 1, 1};
        run_case(rv);

        // Abort in the same cycle as a HOLD handshake: the block still counts.
        d0         = done_total;
        num_blocks = 8'd2;
        start      = 1'b1;
        step();
        start = 1'b0;
        data  = make_block(2);
        exp_q.push_back(data);
        send_block(data, 0, BB);
        check("abort_hs_valid", blk_valid, 1);
        blk_ready = 1'b1;
        abort     = 1'b1;
        step();
        abort = 1'b0;
        check("abort_hs_count", blk_count, 1);
        check("abort_hs_busy", busy, 0);
        step();
        step();
        check("abort_hs_no_done", BB'(done_total - d0), 0);
        check("abort_hs_queue", BB'(exp_q.size()), 0);
        $display("abort with handshake: blk_count=%0d busy=%0d", blk_count, busy);

        // abort beats start in IDLE.
        num_blocks = 8'd1;
        start      = 1'b1;
        abort      = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        check("abort_start_busy", busy, 0);
        step();
        check("abort_start_ready", scan_ready, 0);
        $display("abort+start in IDLE: busy=%0d", busy);

        // Reset pulsed low while a block sits in HOLD.
        exp_q.delete();
        num_blocks = 8'd1;
        start      = 1'b1;
        step();
        start     = 1'b0;
        blk_ready = 1'b0;
        data      = make_block(1);
        send_block(data, 0, BB);
        check("rst_hold_valid", blk_valid, 1);
        #2;
        reset_n = 1'b0;
        start   = 1'b1;
        #1;
        check("rst_async_valid", blk_valid, 0);
        check("rst_async_busy", busy, 0);
        check("rst_async_data", blk_data, 0);
        check("rst_async_count", blk_count, 0);
        step();
        step();
        check("rst_start_ignored", busy, 0);
        check("rst_scan_ready", scan_ready, 0);
        start     = 1'b0;
        blk_ready = 1'b1;
        reset_n   = 1'b1;
        step();
        check("rst_release_idle", busy, 0);
        check("rst_release_done", done, 0);
        $display("reset mid-HOLD: busy=%0d blk_valid=%0d", busy, blk_valid);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
